// File: rtl/dense_layer_if.sv
// Handshake/data bundle between the serial activation source and the dense layer.
interface dense_layer_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned OUT_COUNT  = 10
);
    logic                                  i_valid;
    logic [DATA_WIDTH-1:0]                 i_data;
    logic [OUT_COUNT-1:0][DATA_WIDTH-1:0]  i_weights;
    logic [OUT_COUNT-1:0][DATA_WIDTH-1:0]  i_bias;
    logic                                  o_busy;
    logic                                  o_valid;
    logic [OUT_COUNT-1:0][DATA_WIDTH-1:0]  parallel_out;

    modport master (
        output i_valid, i_data, i_weights, i_bias,
        input  o_busy, o_valid, parallel_out
    );

    modport slave (
        input  i_valid, i_data, i_weights, i_bias,
        output o_busy, o_valid, parallel_out
    );
endinterface

// File: rtl/dense_layer.sv
// Fully connected layer: serial MAC per neuron, then bias, saturation and optional ReLU.
module dense_layer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned IN_COUNT   = 784,
    parameter int unsigned OUT_COUNT  = 10,
    parameter int unsigned RELU       = 1
) (
    input logic           clk,
    input logic           rst,
    dense_layer_if.slave  bus
);
    localparam int unsigned DW   = DATA_WIDTH;
    localparam int unsigned AccW = 2 * DW + $clog2(IN_COUNT);
    // One guard bit so adding the bias can never wrap.
    localparam int unsigned SumW = AccW + 1;
    localparam int unsigned CntW = $clog2(IN_COUNT);

    typedef enum logic [0:0] {StAccum, StFinish} state_e;

    state_e                         state_q, state_d;
    logic [CntW-1:0]                cnt_q, cnt_d;
    logic signed [AccW-1:0]         acc_q [OUT_COUNT];
    logic signed [AccW-1:0]         acc_d [OUT_COUNT];
    logic signed [AccW-1:0]         prod_ext [OUT_COUNT];
    logic [OUT_COUNT-1:0][DW-1:0]   out_q, out_d, res;
    logic                           valid_q, valid_d;

    // Per-neuron product and completion datapath.
    for (genvar j = 0; j < OUT_COUNT; j++) begin : g_neuron
        logic signed [2*DW-1:0] prod;
        logic signed [SumW-1:0] bias_ext, sum, shr;
        logic                   fits;
        logic [DW-1:0]          sat;

        assign prod        = $signed(bus.i_data) * $signed(bus.i_weights[j]);
        assign prod_ext[j] = $signed({{(AccW-2*DW){prod[2*DW-1]}}, prod});
        assign bias_ext    = $signed({{(SumW-DW){bus.i_bias[j][DW-1]}}, bus.i_bias[j]})
                             <<< FRAC_BITS;
        assign sum         = $signed({acc_q[j][AccW-1], acc_q[j]}) + bias_ext;
        // Arithmetic shift floors toward -inf.
        assign shr         = sum >>> FRAC_BITS;
        // Result fits when all bits above the output sign bit match it.
        assign fits        = (&shr[SumW-1:DW-1]) | ~(|shr[SumW-1:DW-1]);
        assign sat         = fits ? shr[DW-1:0] :
                             (shr[SumW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
        assign res[j]      = ((RELU != 0) && sat[DW-1]) ? '0 : sat;
    end

    // Next-state: accumulate accepted elements, complete the vector in one FINISH cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        out_d   = out_q;
        valid_d = 1'b0;
        unique case (state_q)
            StAccum: begin
                if (bus.i_valid) begin
                    for (int j = 0; j < OUT_COUNT; j++) begin
                        acc_d[j] = acc_q[j] + prod_ext[j];
                    end
                    if (cnt_q == CntW'(IN_COUNT - 1)) begin
                        cnt_d   = '0;
                        state_d = StFinish;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StFinish: begin
                out_d   = res;
                valid_d = 1'b1;
                state_d = StAccum;
                for (int j = 0; j < OUT_COUNT; j++) begin
                    acc_d[j] = '0;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            for (int j = 0; j < OUT_COUNT; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            for (int j = 0; j < OUT_COUNT; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    assign bus.o_busy       = (state_q == StFinish);
    assign bus.o_valid      = valid_q;
    assign bus.parallel_out = out_q;
endmodule

// File: doc/dense_layer.md
# dense_layer

Fully connected neuron layer for the MNIST inference pipeline. It consumes one serial stream of signed fixed-point activations, one element per valid cycle. Each of its OUT_COUNT neurons multiply-accumulates that element against a per-neuron weight supplied in the same cycle. After IN_COUNT elements it adds the biases, applies optional ReLU and saturation, and presents all OUT_COUNT results in parallel with a one-cycle valid pulse for the next serialization stage.

## Interface
- DATA_WIDTH, 16: width of activations, weights, biases and outputs; signed two's complement, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS.
- FRAC_BITS, 8: fractional bits of every data-width quantity.
- IN_COUNT, 784: elements per input vector; must be ≥ 2.
- OUT_COUNT, 10: number of neurons / parallel outputs.
- RELU, 1: 1 = clamp negative results to 0; 0 = pass signed result.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  i_data/i_weights carry one vector element this cycle.
- i_data  in  DATA_WIDTH  signed activation element.
- i_weights  in  DATA_WIDTH x OUT_COUNT  weight for each neuron for the current element index.
- i_bias  in  DATA_WIDTH x OUT_COUNT  per-neuron bias; sampled only in FINISH.
- o_busy  out  1  high in FINISH; i_valid is ignored while high.
- o_valid  out  1  single-cycle pulse: parallel_out updated.
- parallel_out  out  DATA_WIDTH x OUT_COUNT  layer results, held until next completion.

## Operation
- State machine: ACCUM (reset state), FINISH.
- ACCUM: each cycle with i_valid=1, every neuron j does acc[j] += i_data * i_weights[j] (full-precision signed product, 2*DATA_WIDTH bits). In_count increments. Cycles with i_valid=0 change nothing (gaps allowed, any length).
- Accumulator width: 2*DATA_WIDTH + $clog2(IN_COUNT); never overflows.
- When the element with index IN_COUNT-1 is accepted, the next state is FINISH and in_count returns to 0.
- FINISH (exactly one cycle):
  - r[j] = (acc[j] + (sign-extended i_bias[j] <<< FRAC_BITS)) >>> FRAC_BITS. The shift is arithmetic and truncates toward −inf.
  - r[j] saturates to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - If RELU=1, negative results become 0.
  - The result registers into parallel_out[j]. All acc clear. The next state is ACCUM.
- i_valid during FINISH is dropped (not counted, not accumulated); o_busy=1 flags this to upstream.
- o_valid=1 in the cycle after FINISH, for exactly one cycle. A new vector's first element may be accepted in that same cycle.
- Reset values: state ACCUM, in_count 0, all acc 0, parallel_out all 0, o_valid 0, o_busy 0.
- rst mid-vector discards partial sums and count. No o_valid is produced for the aborted vector. rst takes priority over i_valid.

## Timing
- Accumulate: 1 cycle per element; the sum is visible in acc at the edge after acceptance.
- Last element accepted at edge k. FINISH is the cycle between edges k and k+1, with o_busy=1. parallel_out is updated at edge k+1. o_valid=1 between edges k+1 and k+2.
- Minimum vector period: IN_COUNT+1 cycles at full input rate.
- parallel_out changes only at the FINISH→ACCUM edge or on reset.

## Test plan
Bench parameters unless stated: DATA_WIDTH=16, FRAC_BITS=8, IN_COUNT=4, OUT_COUNT=2, RELU=1.
- Basic:
  - Stimulus: 4 back-to-back elements i_data=0x0100 (1.0); weights {0x0080, 0xFFC0} (0.5, −0.25); bias {0, 0}.
  - Response: o_busy=1 the cycle after the 4th element, o_valid pulse one cycle later, parallel_out={0x0200, 0x0000}.
- Bias and RELU=0:
  - Stimulus: same vector with RELU=0, bias {0x0080, 0x0040}.
  - Response: parallel_out={0x0280, 0xFF40} (2.5, −0.75).
- Saturation:
  - Stimulus: i_data=0x7F00, weights {0x7F00, 0x8000}, 4 elements.
  - Response: parallel_out={0x7FFF, 0x0000}. With RELU=0: {0x7FFF, 0x8000}.
- Gaps and dropped input:
  - Stimulus: the basic vector with 3 idle cycles between elements, plus i_valid=1 asserted during FINISH.
  - Response: the same result as basic. The FINISH-cycle element is ignored. The next vector counts from 0 and starts in the o_valid cycle.
- Reset mid-vector:
  - Stimulus: 2 elements, assert rst 1 cycle, then a full basic vector.
  - Response: all outputs 0 after reset, no o_valid for the partial vector, then the correct basic result after 4 further elements.
